// File: rtl/ultrasonic_ranger.sv
// ----------------------------------------------------------------------------
// ultrasonic_ranger
//
// Drives an HC-SR04-class ultrasonic sensor and converts the width of its echo
// pulse into a 12-bit distance in centimetres. One measurement is started per
// PERIOD_CLKS clocks. A missing echo is reported as MAX_CM with oTIMEOUT set,
// and a long echo is clamped to MAX_CM.
//
// Build option:
//   AVG4_EN  when defined, oDISTANCE is the floor of the mean of the last four
//            results, using a 14-bit sum. The first result after reset seeds
//            all four history slots. Timeout results are included in the mean.
//            No latency is added.
//            When undefined, oDISTANCE is the latest raw result and no history
//            is kept.
//
// Ports:
//   iCLK_18_4  in   1   system clock (18.432 MHz nominal)
//   iRST_N     in   1   asynchronous active-low reset
//   iECHO      in   1   sensor echo, asynchronous to iCLK_18_4
//   oTRIG      out  1   sensor trigger pulse, TRIG_CLKS wide
//   oDISTANCE  out  12  last measured distance in cm; held between updates
//   oVALID     out  1   one-cycle strobe, coincident with each oDISTANCE update
//   oTIMEOUT   out  1   last measurement saw no echo; held until the next update
//
// Timing, counted from the cycle the FSM enters TRIG (period counter == 0):
//   - oTRIG is a registered copy of "state is TRIG". It is high from cycle 1
//     through cycle TRIG_CLKS.
//   - The echo-wait window opens at cycle TRIG_CLKS. If no echo arrives, oVALID
//     fires WAIT_CLKS cycles after the first cycle in which oTRIG is low.
//   - The reported distance is floor(echo_width / CM_CLKS), clamped to MAX_CM.
// ----------------------------------------------------------------------------
module ultrasonic_ranger #(
  parameter int unsigned TRIG_CLKS   = 185,
  parameter int unsigned CM_CLKS     = 1069,
  parameter int unsigned PERIOD_CLKS = 1105920,
  parameter int unsigned WAIT_CLKS   = 552960,
  parameter int unsigned MAX_CM      = 400
) (
  input  logic        iCLK_18_4,
  input  logic        iRST_N,
  input  logic        iECHO,
  output logic        oTRIG,
  output logic [11:0] oDISTANCE,
  output logic        oVALID,
  output logic        oTIMEOUT
);

  // --------------------------------------------------------------------------
  // Counter widths and terminal counts
  // --------------------------------------------------------------------------
  localparam int unsigned TRIG_W   = (TRIG_CLKS   > 1) ? $clog2(TRIG_CLKS)   : 1;
  localparam int unsigned CM_W     = (CM_CLKS     > 1) ? $clog2(CM_CLKS)     : 1;
  localparam int unsigned WAIT_W   = (WAIT_CLKS   > 1) ? $clog2(WAIT_CLKS)   : 1;
  localparam int unsigned PERIOD_W = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;

  localparam logic [TRIG_W-1:0]   TRIG_LAST   = TRIG_W'(TRIG_CLKS - 1);
  localparam logic [CM_W-1:0]     CM_LAST     = CM_W'(CM_CLKS - 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(WAIT_CLKS - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_CLKS - 1);
  localparam logic [11:0]         MAX_VAL     = 12'(MAX_CM);

  typedef enum logic [2:0] {
    ST_TRIG,
    ST_WAIT,
    ST_MEAS,
    ST_DONE,
    ST_HOLD
  } state_e;

  // --------------------------------------------------------------------------
  // Echo synchronizer and edge detect
  // echo_q[0..1] form the two-flop synchronizer. echo_q[2] holds the previous
  // synced value. Rise and fall are registered, so an edge on the pin reaches
  // the FSM after 3 clocks. Both edges are delayed equally, so the measured
  // width is unaffected.
  // --------------------------------------------------------------------------
  logic [2:0] echo_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      echo_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value of every other flop.
      echo_q <= {echo_q[1:0], iECHO};
      rise_q <= echo_q[1] & ~echo_q[2];
      fall_q <= ~echo_q[1] & echo_q[2];
    end
  end

  // --------------------------------------------------------------------------
  // Free-running period counter. Its wrap marks the start of each cycle, but
  // the wrap is acted on only in HOLD.
  // --------------------------------------------------------------------------
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_d;
  logic                period_wrap;

  always_comb begin
    period_wrap = (period_q == PERIOD_LAST);
    period_d    = period_wrap ? '0 : period_q + 1'b1;
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  // --------------------------------------------------------------------------
  // Measurement FSM
  // cm_q doubles as the result register: the counted centimetres on an echo
  // fall, or MAX_CM on clamp or timeout. res_to_q records whether the result
  // came from a timeout.
  // --------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [TRIG_W-1:0]   trig_cnt_q, trig_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CM_W-1:0]     sub_q,      sub_d;
  logic [11:0]         cm_q,       cm_d;
  logic                res_to_q,   res_to_d;

  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    wait_cnt_d = wait_cnt_q;
    sub_d      = sub_q;
    cm_d       = cm_q;
    res_to_d   = res_to_q;

    unique case (state_q)
      ST_TRIG: begin
        if (trig_cnt_q == TRIG_LAST) begin
          trig_cnt_d = '0;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end else begin
          trig_cnt_d = trig_cnt_q + 1'b1;
        end
      end

      // An echo that is already high when WAIT is entered produces no rise,
      // so this path ends in a timeout.
      ST_WAIT: begin
        if (rise_q) begin
          sub_d   = '0;
          cm_d    = '0;
          state_d = ST_MEAS;
        end else if (wait_cnt_q == WAIT_LAST) begin
          cm_d     = MAX_VAL;
          res_to_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // The cycle that sees the fall still counts. An echo of exactly
      // N*CM_CLKS clocks therefore reports N, and anything shorter truncates.
      ST_MEAS: begin
        if (sub_q == CM_LAST) begin
          sub_d = '0;
          cm_d  = cm_q + 12'd1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
        if (fall_q || (cm_d == MAX_VAL)) begin
          res_to_d = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (period_wrap) begin
          trig_cnt_d = '0;
          state_d    = ST_TRIG;
        end
      end

      default: begin
        state_d = ST_TRIG;
      end
    endcase
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_TRIG;
      trig_cnt_q <= '0;
      wait_cnt_q <= '0;
      sub_q      <= '0;
      cm_q       <= '0;
      res_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      sub_q      <= sub_d;
      cm_q       <= cm_d;
      res_to_q   <= res_to_d;
    end
  end

  // --------------------------------------------------------------------------
  // Value loaded into oDISTANCE on DONE
  // --------------------------------------------------------------------------
  logic [11:0] dist_new;

`ifdef AVG4_EN
  // hist_q[0] is the newest previous result. The new result is summed with
  // the three most recent previous results, so the mean is ready in DONE.
  logic [11:0] hist_q [3];
  logic        hist_vld_q;
  logic [13:0] avg_sum;

  always_comb begin
    if (hist_vld_q) begin
      avg_sum = 14'(cm_q) + 14'(hist_q[0]) + 14'(hist_q[1]) + 14'(hist_q[2]);
    end else begin
      avg_sum = {cm_q, 2'b00};
    end
    dist_new = 12'(avg_sum >> 2);
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      // NOTE: this history is only three words of control-relevant state, so
      // it is reset as flops. A large RAM-style array would be left unreset.
      for (int i = 0; i < 3; i++) begin
        hist_q[i] <= '0;
      end
      hist_vld_q <= 1'b0;
    end else if (state_q == ST_DONE) begin
      if (!hist_vld_q) begin
        for (int i = 0; i < 3; i++) begin
          hist_q[i] <= cm_q;
        end
      end else begin
        hist_q[2] <= hist_q[1];
        hist_q[1] <= hist_q[0];
        hist_q[0] <= cm_q;
      end
      hist_vld_q <= 1'b1;
    end
  end
`else
  assign dist_new = cm_q;
`endif

  // --------------------------------------------------------------------------
  // Registered outputs
  // oTRIG lags the TRIG state by one cycle. This keeps it low during reset and
  // gives exactly TRIG_CLKS high cycles.
  // --------------------------------------------------------------------------
  logic        trig_q;
  logic        valid_q;
  logic        timeout_q;
  logic [11:0] dist_q;

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      dist_q    <= MAX_VAL;
    end else begin
      trig_q  <= (state_q == ST_TRIG);
      valid_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        dist_q    <= dist_new;
        timeout_q <= res_to_q;
      end
    end
  end

  assign oTRIG     = trig_q;
  assign oVALID    = valid_q;
  assign oTIMEOUT  = timeout_q;
  assign oDISTANCE = dist_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// ----------------------------------------------------------------------------
// tb_ultrasonic_ranger
//
// Self-checking bench for ultrasonic_ranger with scaled-down timing
// parameters. Each measurement's expected result comes from these rules:
//   - echo seen    -> min(floor(width / CM_CLKS), MAX_CM), no timeout
//   - no echo seen -> MAX_CM with timeout
// Under AVG4_EN, the result then goes through a last-four-results averaging
// queue. Trigger times follow the period grid: the next trigger rises at the
// first period boundary after the previous result.
// Build option AVG4_EN selects the averaging model, matching the DUT build.
// ----------------------------------------------------------------------------
module tb_ultrasonic_ranger;

  localparam int TRIG_CLKS   = 5;
  localparam int CM_CLKS     = 4;
  localparam int PERIOD_CLKS = 250;
  localparam int WAIT_CLKS   = 200;
  localparam int MAX_CM      = 45;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        echo  = 1'b0;
  logic        oTRIG;
  logic [11:0] oDISTANCE;
  logic        oVALID;
  logic        oTIMEOUT;

  ultrasonic_ranger #(
    .TRIG_CLKS  (TRIG_CLKS),
    .CM_CLKS    (CM_CLKS),
    .PERIOD_CLKS(PERIOD_CLKS),
    .WAIT_CLKS  (WAIT_CLKS),
    .MAX_CM     (MAX_CM)
  ) dut (
    .iCLK_18_4(clk),
    .iRST_N   (rst_n),
    .iECHO    (echo),
    .oTRIG    (oTRIG),
    .oDISTANCE(oDISTANCE),
    .oVALID   (oVALID),
    .oTIMEOUT (oTIMEOUT)
  );

  always #5 clk = ~clk;

  // Counts and observation state
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          n_rise = 0;
  int          n_valid = 0;
  int          n_b2b = 0;
  int          n_silent = 0;
  int          last_rise_cyc = 0;
  int          last_valid_cyc = 0;
  int          exp_rise = 1;
  int          nv_at_rise = 0;
  bit          have_prev = 1'b0;
  logic        prev_trig = 1'b0;
  logic        prev_valid = 1'b0;
  logic [11:0] prev_dist = '0;
  logic [11:0] last_dist = '0;
  logic        last_to = 1'b0;

`ifdef AVG4_EN
  int hist[$];
`endif

  // Reference output for a raw result (averaging window when enabled)
  task automatic model_dist(input int raw, output int exp_d);
`ifdef AVG4_EN
    int sum;
    if (hist.size() == 0) begin
      repeat (4) hist.push_back(raw);
    end else begin
      hist.push_back(raw);
      void'(hist.pop_front());
    end
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    exp_d = sum / 4;
`else
    exp_d = raw;
`endif
  endtask

  // Advance one cycle and observe outputs at the falling edge
  task automatic step();
    @(negedge clk);
    cyc++;
    if (oTRIG === 1'b1 && prev_trig !== 1'b1) begin
      n_rise++;
      last_rise_cyc = cyc;
    end
    if (oVALID === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
      last_dist = oDISTANCE;
      last_to = oTIMEOUT;
      if (prev_valid === 1'b1) n_b2b++;
    end else if (oDISTANCE !== prev_dist) begin
      n_silent++;
    end
    prev_trig = oTRIG;
    prev_valid = oVALID;
    prev_dist = oDISTANCE;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (oTRIG !== 1'b0) begin
      fails++;
      $display("FAIL %s oTRIG: got %b, expected 0", name, oTRIG);
    end
    checks++;
    if (oDISTANCE !== 12'(MAX_CM)) begin
      fails++;
      $display("FAIL %s oDISTANCE: got %0d, expected %0d", name, oDISTANCE, MAX_CM);
    end
    checks++;
    if (oVALID !== 1'b0) begin
      fails++;
      $display("FAIL %s oVALID: got %b, expected 0", name, oVALID);
    end
    checks++;
    if (oTIMEOUT !== 1'b0) begin
      fails++;
      $display("FAIL %s oTIMEOUT: got %b, expected 0", name, oTIMEOUT);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    prev_trig = oTRIG;
    prev_valid = oVALID;
    prev_dist = oDISTANCE;
    exp_rise = 1;
    have_prev = 1'b0;
`ifdef AVG4_EN
    hist.delete();
`endif
  endtask

  // Wait for the next trigger and check its timing and the previous cycle's
  // strobe count
  task automatic wait_rise(input string name, output bit ok);
    int nr0;
    int k;
    nr0 = n_rise;
    k = 0;
    ok = 1'b0;
    while (n_rise == nr0 && k < 3 * PERIOD_CLKS) begin
      step();
      k++;
    end
    checks++;
    if (n_rise == nr0) begin
      fails++;
      $display("FAIL %s trig_rise: no trigger within %0d cycles, expected one", name, k);
      return;
    end
    ok = 1'b1;
    checks++;
    if (last_rise_cyc != exp_rise) begin
      fails++;
      $display("FAIL %s trig_time: rose at cycle %0d, expected %0d", name, last_rise_cyc, exp_rise);
    end
    if (have_prev) begin
      checks++;
      if (n_valid - nv_at_rise != 1) begin
        fails++;
        $display("FAIL %s valid_count: %0d strobes in last cycle, expected 1", name, n_valid - nv_at_rise);
      end
    end
    checks++;
    if (n_b2b != 0 || n_silent != 0) begin
      fails++;
      $display("FAIL %s glitch: %0d back-to-back strobes, %0d silent changes, expected 0 and 0", name, n_b2b, n_silent);
    end
    nv_at_rise = n_valid;
    have_prev = 1'b1;
  endtask

  // One full measurement. Echo starts `delay` cycles after the trigger falls
  // and lasts `width` cycles; width 0 means no echo. pre_high raises the echo
  // before the trigger and holds it until the result.
  task automatic run_meas(input string name, input int delay, input int width, input bit pre_high);
    bit ok;
    bit echo_seen;
    int k;
    int off;
    int nv0;
    int fall_cyc;
    int echo_end;
    int raw;
    int exp_d;
    if (pre_high) echo = 1'b1;
    wait_rise(name, ok);
    if (!ok) return;
    k = 0;
    while (oTRIG === 1'b1 && k < TRIG_CLKS + 5) begin
      step();
      k++;
    end
    fall_cyc = cyc;
    checks++;
    if (fall_cyc - last_rise_cyc != TRIG_CLKS) begin
      fails++;
      $display("FAIL %s trig_width: high %0d cycles, expected %0d", name, fall_cyc - last_rise_cyc, TRIG_CLKS);
    end
    echo_end = (width > 0) ? delay + width : 0;
    nv0 = n_valid;
    off = 0;
    while ((n_valid == nv0 || off < echo_end) && off < 2 * PERIOD_CLKS) begin
      if (!pre_high) echo = (width > 0) && (off >= delay) && (off < echo_end);
      step();
      off++;
      if (pre_high && n_valid != nv0) echo = 1'b0;
    end
    echo = 1'b0;
    checks++;
    if (n_valid == nv0) begin
      fails++;
      $display("FAIL %s valid: no strobe within %0d cycles, expected one", name, off);
      return;
    end
    echo_seen = !pre_high && (width > 0) && (delay < WAIT_CLKS);
    raw = echo_seen ? (((width / CM_CLKS) < MAX_CM) ? width / CM_CLKS : MAX_CM) : MAX_CM;
    model_dist(raw, exp_d);
    checks++;
    if (last_dist !== 12'(exp_d)) begin
      fails++;
      $display("FAIL %s distance: got %0d, expected %0d", name, last_dist, exp_d);
    end
    checks++;
    if (last_to !== !echo_seen) begin
      fails++;
      $display("FAIL %s timeout_flag: got %b, expected %b", name, last_to, !echo_seen);
    end
    if (!echo_seen) begin
      checks++;
      if (last_valid_cyc - fall_cyc != WAIT_CLKS) begin
        fails++;
        $display("FAIL %s timeout_time: strobe %0d cycles after trigger end, expected %0d", name, last_valid_cyc - fall_cyc, WAIT_CLKS);
      end
    end
    exp_rise = ((last_valid_cyc / PERIOD_CLKS) + 1) * PERIOD_CLKS + 1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    echo = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset_hold");
    release_reset();
  endtask

  // Runs straight after reset, so the first result seeds the averaging history
  task automatic test_avg_sequence();
    run_meas("seq_20a", 10, 20 * CM_CLKS, 1'b0);
    run_meas("seq_20b", 10, 20 * CM_CLKS, 1'b0);
    run_meas("seq_40a", 10, 40 * CM_CLKS, 1'b0);
    run_meas("seq_40b", 10, 40 * CM_CLKS, 1'b0);
  endtask

  task automatic test_truncation();
    run_meas("trunc_19", 10, 20 * CM_CLKS - 1, 1'b0);
    run_meas("exact_20", 10, 20 * CM_CLKS, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_meas("random", int'($urandom_range(40, 0)), int'($urandom_range(MAX_CM * CM_CLKS + 20, 1)), 1'b0);
    end
  endtask

  task automatic test_timeout();
    run_meas("no_echo", 0, 0, 1'b0);
    run_meas("late_echo", WAIT_CLKS + 10, 5, 1'b0);
    run_meas("echo_high", 0, 0, 1'b1);
  endtask

  task automatic test_clamp();
    run_meas("clamp_edge_m1", 5, MAX_CM * CM_CLKS - 1, 1'b0);
    run_meas("clamp_edge", 5, MAX_CM * CM_CLKS, 1'b0);
    run_meas("clamp_overrun", 150, MAX_CM * CM_CLKS + 40, 1'b0);
    run_meas("after_overrun", 10, 12 * CM_CLKS, 1'b0);
  endtask

  task automatic test_reset_mid_meas();
    bit ok;
    int k;
    wait_rise("mid_reset", ok);
    if (!ok) return;
    k = 0;
    while (oTRIG === 1'b1 && k < TRIG_CLKS + 5) begin
      step();
      k++;
    end
    echo = 1'b1;
    repeat (60) step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset_async");
    repeat (3) @(negedge clk);
    echo = 1'b0;
    release_reset();
    run_meas("post_reset", 10, 15 * CM_CLKS + 2, 1'b0);
  endtask

  task automatic test_final();
    bit ok;
    wait_rise("final", ok);
  endtask

  initial begin
    test_reset();
    test_avg_sequence();
    test_truncation();
    test_random();
    test_timeout();
    test_clamp();
    test_reset_mid_meas();
    test_final();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
